// File: rtl/divider_if.sv
//------------------------------------------------------------------------------
// divider_if : request/result handshake bundle for the iterative divider
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;

  modport master (
    output in_valid, a, b, op, word, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, op, word, out_ready,
    output in_ready, out_valid, c
  );
endinterface

`default_nettype wire

// File: rtl/divider.sv
//------------------------------------------------------------------------------
// divider : RV64M DIV/DIVU/REM/REMU (+W) radix-2 restoring divider
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] dvd;
  logic [63:0] dvs;
  logic [63:0] rem;
  logic [63:0] c_q;
  logic [6:0]  cnt;
  logic        q_neg;
  logic        r_neg;
  logic        special;
  logic        op_rem;
  logic        word_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_abs;
  logic [63:0] b_abs;
  logic        div_zero;
  logic        ovf;

  logic [64:0] rem_sh;
  logic [64:0] diff;
  logic        ge;
  logic [63:0] rem_n;
  logic [63:0] dvd_n;
  logic [63:0] q_fin;
  logic [63:0] r_fin;
  logic [63:0] q_sgn;
  logic [63:0] r_sgn;
  logic [63:0] res;
  logic [63:0] c_n;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;

  always_comb begin
    is_signed = ~bus.op[0];
    if (bus.word) begin
      a_ext = is_signed ? {{32{bus.a[31]}}, bus.a[31:0]} : {32'd0, bus.a[31:0]};
      b_ext = is_signed ? {{32{bus.b[31]}}, bus.b[31:0]} : {32'd0, bus.b[31:0]};
      ovf   = is_signed && (bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF);
    end else begin
      a_ext = bus.a;
      b_ext = bus.b;
      ovf   = is_signed && (bus.a == 64'h8000_0000_0000_0000) && (bus.b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    a_neg    = is_signed & a_ext[63];
    b_neg    = is_signed & b_ext[63];
    a_abs    = a_neg ? (64'd0 - a_ext) : a_ext;
    b_abs    = b_neg ? (64'd0 - b_ext) : b_ext;
    div_zero = (b_ext == 64'd0);
  end

  // One restoring step; the quotient bit shifts into the vacated dividend LSB.
  always_comb begin
    rem_sh = {rem, dvd[63]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[64];
    rem_n  = ge ? diff[63:0] : rem_sh[63:0];
    dvd_n  = {dvd[62:0], ge};
  end

  // Special cases park their final quotient/remainder in dvd/rem with signs cleared.
  always_comb begin
    q_fin = special ? dvd : dvd_n;
    r_fin = special ? rem : rem_n;
    q_sgn = q_neg ? (64'd0 - q_fin) : q_fin;
    r_sgn = r_neg ? (64'd0 - r_fin) : r_fin;
    res   = op_rem ? r_sgn : q_sgn;
    c_n   = word_q ? {{32{res[31]}}, res[31:0]} : res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= 64'd0;
      cnt         <= 7'd0;
      dvd         <= 64'd0;
      dvs         <= 64'd0;
      rem         <= 64'd0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      special     <= 1'b0;
      op_rem      <= 1'b0;
      word_q      <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_rem     <= bus.op[1];
            word_q     <= bus.word;
            rem        <= 64'd0;
            in_ready_q <= 1'b0;
            state      <= S_CALC;
            if (div_zero || ovf) begin
              special <= 1'b1;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
              dvd     <= div_zero ? 64'hFFFF_FFFF_FFFF_FFFF : a_ext;
              rem     <= div_zero ? a_ext : 64'd0;
              cnt     <= 7'd1;
            end else begin
              special <= 1'b0;
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              dvd     <= bus.word ? {a_abs[31:0], 32'd0} : a_abs;
              dvs     <= b_abs;
              cnt     <= bus.word ? 7'd32 : 7'd64;
            end
          end
        end
        S_CALC: begin
          if (special) begin
            c_q         <= c_n;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            dvd <= dvd_n;
            rem <= rem_n;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
              c_q         <= c_n;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
//------------------------------------------------------------------------------
// tb_divider : directed and randomized checks of divider against an arithmetic model
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divider;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  divider_if bus();

  divider dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic w);
    int                s32a, s32b, q32s, r32s;
    int unsigned       u32a, u32b, q32u, r32u;
    longint            s64a, s64b, q64s, r64s;
    longint unsigned   u64a, u64b, q64u, r64u;
    logic [31:0]       res32;
    logic [63:0]       res64;
    s32a = a[31:0]; s32b = b[31:0]; u32a = a[31:0]; u32b = b[31:0];
    s64a = a;       s64b = b;       u64a = a;       u64b = b;
    if (w) begin
      if (!op[0]) begin
        if (s32b == 0) begin q32s = -1; r32s = s32a; end
        else if (s32a == 32'sh8000_0000 && s32b == -1) begin q32s = s32a; r32s = 0; end
        else begin q32s = s32a / s32b; r32s = s32a % s32b; end
        res32 = op[1] ? r32s : q32s;
      end else begin
        if (u32b == 0) begin q32u = 32'hFFFF_FFFF; r32u = u32a; end
        else begin q32u = u32a / u32b; r32u = u32a % u32b; end
        res32 = op[1] ? r32u : q32u;
      end
      res64 = {{32{res32[31]}}, res32};
    end else begin
      if (!op[0]) begin
        if (s64b == 0) begin q64s = -1; r64s = s64a; end
        else if (a == 64'h8000_0000_0000_0000 && s64b == -1) begin q64s = s64a; r64s = 0; end
        else begin q64s = s64a / s64b; r64s = s64a % s64b; end
        res64 = op[1] ? r64s : q64s;
      end else begin
        if (u64b == 0) begin q64u = '1; r64u = u64a; end
        else begin q64u = u64a / u64b; r64u = u64a % u64b; end
        res64 = op[1] ? r64u : q64u;
      end
    end
    return res64;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op, input logic w);
    logic zero, ovf;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 1 : (w ? 32 : 64);
  endfunction

  // Issue one request, wait for the result, optionally stall the consumer, then retire.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic w, input logic [63:0] exp,
                        input int exp_lat, input int hold);
    int n;
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    bus.a = a; bus.b = b; bus.op = op; bus.word = w; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_c"}, bus.c, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_c"}, bus.c, exp);
      check({tag, "_hold_ir"}, bus.in_ready, 1'b0);
      check({tag, "_hold_ov"}, bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_ret_ov"}, bus.out_valid, 1'b0);
    check({tag, "_ret_ir"}, bus.in_ready, 1'b1);
  endtask

  task automatic run_rand(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic w, input int hold);
    run_op(tag, a, b, op, w, ref_div(a, b, op, w), ref_lat(a, b, op, w), hold);
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    bus.a = a; bus.b = b; bus.op = op; bus.word = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  localparam logic [63:0] M7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MN = 64'h8000_0000_0000_0000;

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    logic        rw;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0; bus.word = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ir", bus.in_ready, 1'b1);
    check("rst_ov", bus.out_valid, 1'b0);
    check("rst_c", bus.c, 64'd0);

    run_op("divu",  64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 64, 0);
    run_op("remu",  64'd100, 64'd7, 2'b11, 1'b0, 64'd2,  64, 0);
    run_op("div_n", M7, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    run_op("rem_n", M7, 64'd2, 2'b10, 1'b0, M1, 64, 0);
    run_op("rem_p", 64'd7, M2, 2'b10, 1'b0, 64'd1, 64, 0);
    run_op("divu0", 64'd5, 64'd0, 2'b01, 1'b0, M1, 1, 0);
    run_op("rem0",  64'd5, 64'd0, 2'b10, 1'b0, 64'd5, 1, 0);
    run_op("ovf_q", MN, M1, 2'b00, 1'b0, MN, 1, 0);
    run_op("ovf_r", MN, M1, 2'b10, 1'b0, 64'd0, 1, 0);
    run_op("divw",  64'h1_8000_0000, 64'hFFFF_FFFF, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw", 64'hFFFF_FFFF, 64'd2, 2'b01, 1'b1, 64'h7FFF_FFFF, 32, 0);
    run_op("bp",    64'd1000, 64'd9, 2'b01, 1'b0, 64'd111, 64, 10);

    start_op(64'd100, 64'd7, 2'b01);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_ir", bus.in_ready, 1'b1);
    check("flush_ov", bus.out_valid, 1'b0);
    watch_no_valid("flush_noval", 80);

    bus.a = 64'd9; bus.b = 64'd3; bus.op = 2'b01; bus.word = 1'b0;
    bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_req_ir", bus.in_ready, 1'b1);
    watch_no_valid("flush_req_noval", 70);

    start_op(64'd100, 64'd7, 2'b01);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mrst_ir", bus.in_ready, 1'b1);
    check("mrst_ov", bus.out_valid, 1'b0);
    check("mrst_c", bus.c, 64'd0);
    watch_no_valid("mrst_noval", 80);

    run_op("recover", 64'd81, 64'd9, 2'b01, 1'b0, 64'd9, 64, 0);

    for (int i = 0; i < 30; i++) begin
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 20));
        2: rb = M1 - 64'($urandom_range(0, 20));
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) begin ra = MN; rb = M1; end
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      run_rand("rand", ra, rb, rop, rw, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divider.md
# divider

Iterative RV64M integer divide/remainder unit in the execute stage. It covers DIV, DIVU, REM, REMU and their W variants, which the single-cycle ALU does not handle. It takes one request per valid/ready handshake, computes the result with a radix-2 restoring shift-subtract loop, and holds the result until the pipeline accepts it. Divide-by-zero and signed overflow bypass the loop and complete in one cycle.

## Interface
- No parameters; data width is fixed at 64 (`u64`).
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous abort of any in-flight operation.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `a` in 64: dividend.
- `b` in 64: divisor.
- `op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `word` in 1: W variant; operates on bits [31:0] and sign-extends the 32-bit result.
- `out_valid` out 1: result `c` is valid.
- `out_ready` in 1: consumer takes the result.
- `c` out 64: quotient or remainder.

## Operation
- States: IDLE, CALC, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, latch `op` and `word`.
  - Form operands: for W, use `a[31:0]`/`b[31:0]`, sign-extended if signed and zero-extended if unsigned.
  - Signed ops: latch `|a|`, `|b|`, `q_neg = sign(a)^sign(b)` and `r_neg = sign(a)`.
  - Special case divisor == 0 (after W truncation) goes to DONE:
    - quotient = all ones;
    - remainder = dividend (the truncated, extended value).
  - Special case signed overflow (64-bit: a=0x8000_0000_0000_0000, b=-1; W: a[31:0]=0x8000_0000, b[31:0]=0xFFFF_FFFF) goes to DONE:
    - quotient = dividend;
    - remainder = 0.
  - Otherwise, load the iteration counter with 64 (W: 32) and go to CALC.
- CALC, once per cycle:
  - `rem = {rem, dividend_msb}`; shift the dividend left.
  - If `rem >= divisor`: `rem -= divisor` and shift in quotient bit 1; else shift in 0.
  - Decrement the counter; when the counter reaches 1, go to DONE on that edge.
  - The W variant iterates only over the low 32 bits.
- Entering DONE:
  - Apply the signs: negate the quotient if `q_neg`; negate the remainder if `r_neg`.
  - Select quotient (`op` 00/01) or remainder (`op` 10/11).
  - For W, `c = {{32{r[31]}}, r[31:0]}`.
  - Register `c`.
- DONE
  - `out_valid`=1 and `c` is stable until `out_valid && out_ready`, then go to IDLE.
  - `in_ready`=0 in CALC and DONE; no overlap between output handshake and new request.
- `flush`
  - In any state: next state IDLE, `out_valid`=0, the result is discarded.
  - `flush` together with `in_valid` in IDLE: the request is not accepted.
- Arithmetic is internally unsigned 64-bit with a 65-bit remainder compare; negation is two's complement. The overflow case never reaches the negation path.

## Timing
- After reset: state IDLE, `in_ready`=1, `out_valid`=0, `c`=0, counter=0.
- A `reset` asserted mid-operation aborts it identically to `flush` and also clears `c`.
- Accept at edge T (`in_valid && in_ready`).
- Normal 64-bit op: `out_valid` rises after edge T+64 (64 CALC cycles, result registered on the last one). For W, it rises after edge T+32.
- Special case: `out_valid`=1 after edge T+1.
- Result handshake at edge R: `out_valid`=0 and `in_ready`=1 after R. The earliest next accept is edge R+1.
- Throughput: one 64-bit op per 66 cycles when `out_ready` is held high.
- Outputs are fully registered; no combinational path from inputs to `in_ready`, `out_valid` or `c`.

## Test plan
- DIVU a=100, b=7, word=0 -> `out_valid` 64 cycles after accept, `c`=14; REMU on the same operands -> `c`=2.
- DIV a=-7, b=2 -> `c`=0xFFFF_FFFF_FFFF_FFFD (-3); REM a=-7, b=2 -> `c`=-1; REM a=7, b=-2 -> `c`=1.
- DIVU a=5, b=0 -> `c`=0xFFFF_FFFF_FFFF_FFFF one cycle after accept; REM a=5, b=0 -> `c`=5.
- DIV a=0x8000_0000_0000_0000, b=-1 -> `c`=0x8000_0000_0000_0000 with 1-cycle latency; REM on the same operands -> `c`=0.
- DIVW a=0x1_8000_0000, b=0xFFFF_FFFF -> `c`=0xFFFF_FFFF_8000_0000; DIVUW a=0xFFFF_FFFF, b=2 -> `c`=0x7FFF_FFFF after 32 iterations.
- Backpressure and abort:
  - Hold `out_ready`=0 for 10 cycles after `out_valid` -> `c` stable, `in_ready`=0, then a one-cycle handshake returns the unit to IDLE.
  - Assert `flush` at cycle 20 of CALC -> `out_valid` never rises and `in_ready`=1 next cycle.
  - Assert `reset` mid-CALC -> same abort, and `c`=0.
